uart_tx_param: RTL and testbench

//  Parametrised UART transmitter; next generation of the fixed 8N1 TX FSM.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx_param_if.sv | 12 +
 rtl/uart_baud_gen.sv | 28 ++
 rtl/uart_tx_param.sv | 138 +++++++++++++
 tb/tb_uart_tx_param.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared constants for the parametrised UART transmitter: FSM state encodings,
// parity mode selectors and the parity helper used at word capture.
package uart_pkg;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Unused upper bits must be zero so they do not disturb the XOR.
  function automatic logic parity_bit(input logic [8:0] data, input int mode);
    logic p;
    p = 1'b0;
    case (mode)
      PARITY_EVEN: p = ^data;
      PARITY_ODD:  p = ~(^data);
      default:     p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_tx_param_if.sv
// Host-side valid/ready word handshake into the UART transmitter.
// master = host/FIFO side, slave = transmitter side.
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period divider: counts 0..CLKS_PER_BIT-1 while enabled and pulses tick
// on the last count; clear forces the phase back to zero.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clear,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: one word per valid/ready handshake, framed as
// start, DATA_BITS data LSB-first, optional parity and 1 or 2 stop bits.
//
// state  | meaning
// IDLE   | line high, ready for a word; first IDLE cycle after a frame carries done
// START  | start bit (low) for one bit period
// DATA   | data bits from the shift register, LSB first
// PARITY | parity bit captured at accept (only when PARITY_MODE != 0)
// STOP   | STOP_BITS periods of high line
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_BITS    = 8,
  parameter int PARITY_MODE  = 0,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 434
) (
  input  logic              clk,
  input  logic              reset,
  uart_tx_param_if.slave    host,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx_param: DATA_BITS must be in 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity_mode
    $error("uart_tx_param: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
  end

  localparam logic [3:0] LAST_BIT  = 4'(DATA_BITS - 1);
  localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

  logic [2:0]           state;
  logic [DATA_BITS-1:0] shreg;
  logic [3:0]           bit_cnt;
  logic                 stop_cnt;
  logic                 par_bit;
  logic                 accept;
  logic                 tick;

  assign host.tx_ready = (state == IDLE) && !reset;
  assign accept        = host.tx_valid && host.tx_ready;

  // Cleared on accept so the start bit always lasts a full period.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_gen (
    .clk  (clk),
    .reset(reset),
    .en   (busy),
    .clear(accept),
    .tick (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      shreg    <= '0;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      par_bit  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shreg    <= host.tx_data;
            par_bit  <= parity_bit(9'(host.tx_data), PARITY_MODE);
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end
        START: begin
          if (tick) begin
            tx    <= shreg[0];
            shreg <= shreg >> 1;
            state <= DATA;
          end
        end
        DATA: begin
          if (tick) begin
            if (bit_cnt == LAST_BIT) begin
              if (PARITY_MODE != PARITY_NONE) begin
                tx    <= par_bit;
                state <= PARITY;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (tick) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
        STOP: begin
          if (tick) begin
            if (stop_cnt == LAST_STOP) begin
              state <= IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Bench for uart_tx_param: five configurations side by side, each frame checked
// cycle by cycle against a bit list built from the frame format.
module tb_uart_tx_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  // Per-instance configuration: 8N1, 8E1, 8O1, 7N2, 5E2 (the last at 3 clks/bit).
  int cfg_db   [5] = '{8, 8, 8, 7, 5};
  int cfg_par  [5] = '{0, 1, 2, 0, 1};
  int cfg_stop [5] = '{1, 1, 1, 2, 2};
  int cfg_clks [5] = '{4, 4, 4, 4, 3};

  logic [8:0] data_a [5];
  logic [4:0] valid_a;
  logic [4:0] ready_a;
  logic [4:0] tx_a;
  logic [4:0] busy_a;
  logic [4:0] done_a;

  int n_cmp = 0;
  int n_err = 0;

  uart_tx_param_if #(.DATA_BITS(8)) bus0 ();
  uart_tx_param_if #(.DATA_BITS(8)) bus1 ();
  uart_tx_param_if #(.DATA_BITS(8)) bus2 ();
  uart_tx_param_if #(.DATA_BITS(7)) bus3 ();
  uart_tx_param_if #(.DATA_BITS(5)) bus4 ();

  assign bus0.tx_data = data_a[0][7:0];
  assign bus1.tx_data = data_a[1][7:0];
  assign bus2.tx_data = data_a[2][7:0];
  assign bus3.tx_data = data_a[3][6:0];
  assign bus4.tx_data = data_a[4][4:0];
  assign bus0.tx_valid = valid_a[0];
  assign bus1.tx_valid = valid_a[1];
  assign bus2.tx_valid = valid_a[2];
  assign bus3.tx_valid = valid_a[3];
  assign bus4.tx_valid = valid_a[4];
  assign ready_a = {bus4.tx_ready, bus3.tx_ready, bus2.tx_ready, bus1.tx_ready, bus0.tx_ready};

  uart_tx_param #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1), .CLKS_PER_BIT(4)) dut0 (
    .clk(clk), .reset(reset), .host(bus0), .tx(tx_a[0]), .busy(busy_a[0]), .done(done_a[0]));
  uart_tx_param #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1), .CLKS_PER_BIT(4)) dut1 (
    .clk(clk), .reset(reset), .host(bus1), .tx(tx_a[1]), .busy(busy_a[1]), .done(done_a[1]));
  uart_tx_param #(.DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1), .CLKS_PER_BIT(4)) dut2 (
    .clk(clk), .reset(reset), .host(bus2), .tx(tx_a[2]), .busy(busy_a[2]), .done(done_a[2]));
  uart_tx_param #(.DATA_BITS(7), .PARITY_MODE(0), .STOP_BITS(2), .CLKS_PER_BIT(4)) dut3 (
    .clk(clk), .reset(reset), .host(bus3), .tx(tx_a[3]), .busy(busy_a[3]), .done(done_a[3]));
  uart_tx_param #(.DATA_BITS(5), .PARITY_MODE(1), .STOP_BITS(2), .CLKS_PER_BIT(3)) dut4 (
    .clk(clk), .reset(reset), .host(bus4), .tx(tx_a[4]), .busy(busy_a[4]), .done(done_a[4]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_all(input string tag);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("%s_tx%0d", tag, k),    32'(tx_a[k]),    32'd1);
      chk($sformatf("%s_busy%0d", tag, k),  32'(busy_a[k]),  32'd0);
      chk($sformatf("%s_done%0d", tag, k),  32'(done_a[k]),  32'd0);
      chk($sformatf("%s_ready%0d", tag, k), 32'(ready_a[k]), 32'd0);
    end
  endtask

  // mode 0: drop valid after accept; 1: keep valid high for a back-to-back word;
  // 2: scramble tx_data and pulse tx_valid while the frame is in flight.
  task automatic run_frame(input int k, input logic [8:0] d, input int mode, input string tag);
    logic [8:0] mask;
    logic [8:0] dm;
    bit         bits [$];
    int         nsamp;
    int         s;
    mask = 9'((1 << cfg_db[k]) - 1);
    dm   = d & mask;
    bits = {};
    bits.push_back(1'b0);
    for (int i = 0; i < cfg_db[k]; i++) bits.push_back(dm[i]);
    if (cfg_par[k] != 0) bits.push_back((($countones(dm) % 2) == 1) ^ (cfg_par[k] == 2));
    for (int i = 0; i < cfg_stop[k]; i++) bits.push_back(1'b1);
    nsamp = bits.size() * cfg_clks[k];

    data_a[k]  = d;
    valid_a[k] = 1'b1;
    chk($sformatf("%s_ready_pre", tag), 32'(ready_a[k]), 32'd1);
    @(posedge clk);
    @(negedge clk);
    if (mode != 1) valid_a[k] = 1'b0;
    s = 0;
    foreach (bits[b]) begin
      for (int c = 0; c < cfg_clks[k]; c++) begin
        chk($sformatf("%s_tx_b%0d_c%0d", tag, b, c), 32'(tx_a[k]), 32'(bits[b]));
        chk($sformatf("%s_busy_b%0d_c%0d", tag, b, c), 32'(busy_a[k]), 32'd1);
        chk($sformatf("%s_done_b%0d_c%0d", tag, b, c), 32'(done_a[k]), 32'd0);
        s++;
        if (mode == 2) begin
          data_a[k]  = 9'($urandom);
          valid_a[k] = (s == nsamp) ? 1'b0 : 1'($urandom_range(0, 1));
        end
        @(negedge clk);
      end
    end
    chk($sformatf("%s_done_end", tag),  32'(done_a[k]),  32'd1);
    chk($sformatf("%s_busy_end", tag),  32'(busy_a[k]),  32'd0);
    chk($sformatf("%s_tx_end", tag),    32'(tx_a[k]),    32'd1);
    chk($sformatf("%s_ready_end", tag), 32'(ready_a[k]), 32'd1);
    if (mode != 1) begin
      @(negedge clk);
      chk($sformatf("%s_done_after", tag), 32'(done_a[k]), 32'd0);
      chk($sformatf("%s_busy_after", tag), 32'(busy_a[k]), 32'd0);
      chk($sformatf("%s_tx_after", tag),   32'(tx_a[k]),   32'd1);
    end
  endtask

  initial begin
    int k;
    int n;
    int mode;
    for (int i = 0; i < 5; i++) data_a[i] = '0;
    valid_a = '0;

    // Power-on reset, with a host already presenting a word.
    valid_a[0] = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_all("por");
    reset = 1'b0;
    valid_a[0] = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) chk($sformatf("por_release_ready%0d", i), 32'(ready_a[i]), 32'd1);
    @(negedge clk);

    // Directed frames from the format examples.
    run_frame(0, 9'h0A5, 0, "n81_a5");
    run_frame(1, 9'h0A5, 0, "e81_a5");
    run_frame(2, 9'h0A5, 0, "o81_a5");
    run_frame(3, 9'h041, 0, "n72_41");
    run_frame(4, 9'h013, 0, "e52_13");

    // Back-to-back with tx_valid held, then a frame disturbed while busy.
    run_frame(0, 9'h000, 1, "b2b_00");
    run_frame(0, 9'h0FF, 0, "b2b_ff");
    run_frame(0, 9'h03C, 2, "dist_3c");
    repeat (8) begin
      chk("dist_idle_tx",   32'(tx_a[0]),   32'd1);
      chk("dist_idle_busy", 32'(busy_a[0]), 32'd0);
      @(negedge clk);
    end

    // Reset while idle.
    reset = 1'b1;
    #1;
    chk_reset_all("rst_idle");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset mid-frame while the line is low (7N2 0x41, data bit 2).
    data_a[3]  = 9'h041;
    valid_a[3] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid_a[3] = 1'b0;
    repeat (13) @(negedge clk);
    chk("midframe_tx_low", 32'(tx_a[3]),   32'd0);
    chk("midframe_busy",   32'(busy_a[3]), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_reset_all("rst_frame");
    @(negedge clk);
    reset = 1'b0;
    repeat (45) begin
      chk("post_rst_tx",   32'(tx_a[3]),   32'd1);
      chk("post_rst_done", 32'(done_a[3]), 32'd0);
      chk("post_rst_busy", 32'(busy_a[3]), 32'd0);
      @(negedge clk);
    end
    run_frame(3, 9'h07F, 0, "post_rst_frame");

    // Randomised traffic across all configurations.
    repeat (14) begin
      k = $urandom_range(0, 4);
      n = $urandom_range(1, 3);
      for (int j = 0; j < n; j++) begin
        if (j < n - 1) mode = 1;
        else mode = ($urandom_range(0, 1) == 1) ? 2 : 0;
        run_frame(k, 9'($urandom), mode, $sformatf("rnd_i%0d_f%0d_m%0d", k, j, mode));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
